// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding and index-width helper shared by mem_arbiter and rr_arbiter
package mem_arb_pkg;
   localparam int ST_W = 2;
   localparam logic [ST_W-1:0] IDLE   = 2'd0;
   localparam logic [ST_W-1:0] ACCESS = 2'd1;
   localparam logic [ST_W-1:0] RESP   = 2'd2;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational masked-priority picker; scans from i_ptr upward with wrap,
// first requester wins (i_ptr held at 0 gives plain fixed priority)
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);
   logic          w_found;
   logic [IW-1:0] w_j;
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int k = 0; k < N; k++) begin
         w_j = IW'((int'(i_ptr) + k) % N);
         if (!w_found && i_req[w_j]) begin
            w_found   = 1'b1;
            o_idx     = w_j;
            o_gnt[w_j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter onto one PSEL/PREADY memory port, one access at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64
)(
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic [NUM_PORTS-1:0]          HTRANS,
   input  logic [NUM_PORTS*ADDR_W-1:0]   HADDR,
   input  logic [NUM_PORTS-1:0]          HWRITE,
   input  logic [NUM_PORTS*DATA_W-1:0]   HWDATA,
   output logic [NUM_PORTS-1:0]          HREADY,
   output logic [DATA_W-1:0]             HRDATA,
   output logic [NUM_PORTS-1:0]          stall,
   output logic                          PSEL,
   output logic [ADDR_W-1:0]             PADDR,
   output logic                          PWRITE,
   output logic [DATA_W-1:0]             PWDATA,
   input  logic                          PREADY,
   input  logic [DATA_W-1:0]             PRDATA
);
   localparam int IW = idx_w(NUM_PORTS);
   logic [ST_W-1:0]      r_state;
   logic                 r_psel, r_pwrite;
   logic [ADDR_W-1:0]    r_paddr;
   logic [DATA_W-1:0]    r_pwdata, r_hrdata;
   logic [NUM_PORTS-1:0] r_hready, r_grant_oh, w_gnt;
   logic [IW-1:0]        w_ptr, w_idx;
   rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
      .i_req (HTRANS),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );
`ifdef MEM_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [IW-1:0] r_grant, r_rr_ptr;
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else if (r_state == IDLE && |HTRANS) begin
         r_grant <= w_idx;
      end else if (r_state == ACCESS && PREADY) begin
         r_rr_ptr <= (r_grant == IW'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;
      end
   end
   assign w_ptr = r_rr_ptr;
`endif
   // HREADY defaults low each cycle so the completion is a single-cycle pulse during RESP
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= IDLE;
         r_psel     <= 1'b0;
         r_paddr    <= '0;
         r_pwrite   <= 1'b0;
         r_pwdata   <= '0;
         r_hrdata   <= '0;
         r_hready   <= '0;
         r_grant_oh <= '0;
      end else begin
         r_hready <= '0;
         if (r_state == IDLE && |HTRANS) begin
            r_state    <= ACCESS;
            r_psel     <= 1'b1;
            r_grant_oh <= w_gnt;
            r_paddr    <= HADDR[w_idx*ADDR_W +: ADDR_W];
            r_pwrite   <= HWRITE[w_idx];
            r_pwdata   <= HWDATA[w_idx*DATA_W +: DATA_W];
         end else if (r_state == ACCESS && PREADY) begin
            r_state  <= RESP;
            r_psel   <= 1'b0;
            r_hready <= r_grant_oh;
            if (!r_pwrite) r_hrdata <= PRDATA;
         end else if (r_state != IDLE && r_state != ACCESS) begin
            r_state <= IDLE;
         end
      end
   end
   assign HREADY = r_hready;
   assign HRDATA = r_hrdata;
   assign stall  = HTRANS & ~r_hready;
   assign PSEL   = r_psel;
   assign PADDR  = r_paddr;
   assign PWRITE = r_pwrite;
   assign PWDATA = r_pwdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for a 2-port/64-bit and a 4-port/16-bit mem_arbiter
module tb_mem_arbiter;
   typedef logic [67:0] exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int checks = 0;
   int errors = 0;
   int done_a = 0;
   int done_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic [1:0]   ht_a = '0, hw_a = '0, hr_a, st_a;
   logic [127:0] ha_a = '0, hwd_a = '0;
   logic [63:0]  hrd_a, pa_a, pwd_a, prd_a, fixv_a = '0;
   logic         ps_a, pw_a, pr_a = 1'b0, fix_a = 1'b0;
   assign prd_a = fix_a ? fixv_a : pa_a + 64'h1000;
   mem_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64)) dut_a (
      .HCLK(clk), .HRESET(rst), .HTRANS(ht_a), .HADDR(ha_a), .HWRITE(hw_a), .HWDATA(hwd_a),
      .HREADY(hr_a), .HRDATA(hrd_a), .stall(st_a), .PSEL(ps_a), .PADDR(pa_a), .PWRITE(pw_a),
      .PWDATA(pwd_a), .PREADY(pr_a), .PRDATA(prd_a)
   );
   logic [3:0]  ht_b = '0, hw_b = '0, hr_b, st_b;
   logic [63:0] ha_b = '0, hwd_b = '0;
   logic [15:0] hrd_b, pa_b, pwd_b, prd_b;
   logic        ps_b, pw_b;
   assign prd_b = pa_b ^ 16'hA500;
   mem_arbiter #(.NUM_PORTS(4), .ADDR_W(16), .DATA_W(16)) dut_b (
      .HCLK(clk), .HRESET(rst), .HTRANS(ht_b), .HADDR(ha_b), .HWRITE(hw_b), .HWDATA(hwd_b),
      .HREADY(hr_b), .HRDATA(hrd_b), .stall(st_b), .PSEL(ps_b), .PADDR(pa_b), .PWRITE(pw_b),
      .PWDATA(pwd_b), .PREADY(1'b1), .PRDATA(prd_b)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (hr_a != 2'b00) begin
         done_a++;
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_hready_a: got %b expected none", hr_a);
         end else begin
            e = q_a.pop_front();
            chk("hready_a", 64'(hr_a), 64'(e[67:64]));
            chk("hrdata_a", hrd_a, e[63:0]);
         end
      end
      if (hr_b != 4'b0000) begin
         done_b++;
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_hready_b: got %b expected none", hr_b);
         end else begin
            e = q_b.pop_front();
            chk("hready_b", 64'(hr_b), 64'(e[67:64]));
            chk("hrdata_b", 64'(hrd_b), e[63:0]);
         end
      end
   end
   task automatic wait_done(input int which, input int target);
      int n = 0;
      while ((which == 0 ? done_a : done_b) < target && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk($sformatf("completions_%0d", which), 64'(which == 0 ? done_a : done_b), 64'(target));
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_psel", 64'(ps_a), 64'h0);
      chk("rst_hready", 64'(hr_a), 64'h0);
      chk("rst_paddr", pa_a, 64'h0);
      chk("rst_pwdata", pwd_a, 64'h0);
      chk("rst_hrdata", hrd_a, 64'h0);
      chk("rst_pwrite", 64'(pw_a), 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      // reset while an access is stalled on PREADY
      ha_a[63:0] = 64'h200;
      ht_a = 2'b01;
      @(posedge clk);
      @(negedge clk);
      chk("t1_psel_up", 64'(ps_a), 64'h1);
      chk("t1_paddr", pa_a, 64'h200);
      #2 rst = 1'b1;
      #1;
      chk("t1_psel_async", 64'(ps_a), 64'h0);
      chk("t1_paddr_rst", pa_a, 64'h0);
      chk("t1_hready_rst", 64'(hr_a), 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      pr_a = 1'b1;
      q_a.push_back({4'b0001, 64'h1200});
      wait_done(0, 1);
      ht_a = 2'b00;
      // single read on port 1, fixed memory data
      fix_a = 1'b1;
      fixv_a = 64'hDEAD;
      ha_a[127:64] = 64'h100;
      ht_a = 2'b10;
      q_a.push_back({4'b0010, 64'hDEAD});
      @(posedge clk);
      @(negedge clk);
      chk("t2_psel", 64'(ps_a), 64'h1);
      chk("t2_paddr", pa_a, 64'h100);
      chk("t2_pwrite", 64'(pw_a), 64'h0);
      chk("t2_hready_early", 64'(hr_a), 64'h0);
      @(negedge clk);
      chk("t2_hready", 64'(hr_a), 64'h2);
      wait_done(0, 2);
      ht_a = 2'b00;
      fix_a = 1'b0;
      // both ports request continuously
      @(posedge clk);
      #1;
      ha_a = {64'h300, 64'h200};
      ht_a = 2'b11;
`ifdef MEM_ARB_FIXED_PRIO_EN
      repeat (4) q_a.push_back({4'b0001, 64'h1200});
`else
      q_a.push_back({4'b0001, 64'h1200});
      q_a.push_back({4'b0010, 64'h1300});
      q_a.push_back({4'b0001, 64'h1200});
      q_a.push_back({4'b0010, 64'h1300});
`endif
      @(posedge clk);
      @(negedge clk);
      chk("t3_stall_both", 64'(st_a), 64'h3);
      @(negedge clk);
      chk("t3_stall_waiter", 64'(st_a), 64'h2);
      wait_done(0, 6);
      ht_a = 2'b00;
      // write on port 0 with PREADY held low for five cycles
      @(posedge clk);
      #1;
      pr_a = 1'b0;
      ha_a[63:0] = 64'h40;
      hwd_a[63:0] = 64'h55;
      hw_a = 2'b01;
      ht_a = 2'b01;
`ifdef MEM_ARB_FIXED_PRIO_EN
      q_a.push_back({4'b0001, 64'h1200});
`else
      q_a.push_back({4'b0001, 64'h1300});
`endif
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t4_psel_%0d", i), 64'(ps_a), 64'h1);
         chk($sformatf("t4_paddr_%0d", i), pa_a, 64'h40);
         chk($sformatf("t4_pwdata_%0d", i), pwd_a, 64'h55);
         chk($sformatf("t4_pwrite_%0d", i), 64'(pw_a), 64'h1);
         chk($sformatf("t4_hready_%0d", i), 64'(hr_a), 64'h0);
         chk($sformatf("t4_stall_%0d", i), 64'(st_a), 64'h1);
      end
      pr_a = 1'b1;
      @(negedge clk);
      chk("t4_hready", 64'(hr_a), 64'h1);
      wait_done(0, 7);
      ht_a = 2'b00;
      hw_a = 2'b00;
      // 4-port: serve port 1 to move the pointer to 2, then ports 1 and 3 together
      @(posedge clk);
      #1;
      ha_b = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
      ht_b = 4'b0010;
      q_b.push_back({4'b0010, 64'hA510});
      wait_done(1, 1);
      ht_b = 4'b0000;
      @(posedge clk);
      #1;
      ht_b = 4'b1010;
`ifdef MEM_ARB_FIXED_PRIO_EN
      q_b.push_back({4'b0010, 64'hA510});
      q_b.push_back({4'b1000, 64'hA530});
      wait_done(1, 2);
      ht_b = 4'b1000;
`else
      q_b.push_back({4'b1000, 64'hA530});
      q_b.push_back({4'b0010, 64'hA510});
      wait_done(1, 2);
      ht_b = 4'b0010;
`endif
      wait_done(1, 3);
      ht_b = 4'b0000;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("sb_a_empty", 64'(q_a.size()), 64'h0);
      chk("sb_b_empty", 64'(q_b.size()), 64'h0);
      chk("idle_psel_a", 64'(ps_a), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
